// File: rtl/register_sequencer.sv
// Command-side master for a parallel register: takes READ/LOAD/INCR/CLR commands,
// drives the register's ctrl/data_in, then returns the readback value and a wrap flag.
module register_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 async_nreset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_data,
    input  logic [CNT_WIDTH-1:0] cmd_count,
    output logic [1:0]           reg_ctrl,
    output logic [WIDTH-1:0]     reg_data_in,
    input  logic [WIDTH-1:0]     reg_data_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_wrap,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_INCR = 2'd2;

    localparam logic [1:0] CTRL_NONE = 2'd0;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     data_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 wrap_q;
    logic                 accept;
    logic                 rsp_done;
    logic                 incr_cycle;

    assign accept     = cmd_valid & cmd_ready;
    assign rsp_done   = rsp_valid & rsp_ready;
    assign incr_cycle = (state == ST_ISSUE) && (op_q == OP_INCR);

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_READ || (cmd_op == OP_INCR && cmd_count == '0))
                        state_next = ST_RESP;
                    else
                        state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // LOAD/CLR take one cycle; INCR leaves on its last repeat.
                if (op_q != OP_INCR || count_q <= CNT_WIDTH'(1))
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_done)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            op_q    <= OP_READ;
            data_q  <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (accept) begin
            op_q    <= cmd_op;
            count_q <= cmd_count;
            wrap_q  <= 1'b0;
            // data_in only moves when the register is about to be driven, so it
            // otherwise holds whatever was last presented to the register.
            if (state_next == ST_ISSUE)
                data_q <= cmd_data;
        end else if (incr_cycle) begin
            count_q <= count_q - CNT_WIDTH'(1);
            if (reg_data_out == '1)
                wrap_q <= 1'b1;
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign reg_ctrl    = (state == ST_ISSUE) ? op_q : CTRL_NONE;
    assign reg_data_in = data_q;
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_data    = reg_data_out;
    assign rsp_wrap    = (state == ST_RESP) & wrap_q;

endmodule
